piezo_tone_gen: RTL and testbench

Downstream stage of the memory-game controller: converts its 4-bit note code (`piezo_out`) into a square wave for the piezo buzzer. It also overlays two sound effects on that tone:
- an error buzz, triggered by the controller's `miss` flag;
- a two-tone chime, triggered by the controller's `change_num` pulse.

It owns no game logic. It only turns codes and event flags into audio timing.

---
 rtl/piezo_tone_gen.sv | 164 ++++++++++++++++
 tb/tb_piezo_tone_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_tone_gen.sv
// Square-wave tone generator for the memory-game piezo: follows the note code
// and overlays an error buzz (miss edge) and a two-tone chime (change_num).
module piezo_tone_gen #(
    parameter int unsigned DIV_SHIFT = 0,
    parameter int unsigned ERR_HALF  = 250000,
    parameter int unsigned ERR_LEN   = 25000000,
    parameter int unsigned CHIME_LEN = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] note,
    input  logic       miss,
    input  logic       change_num,
    input  logic       enable,
    output logic       piezo,
    output logic [3:0] active_note,
    output logic       busy
);

    // Tone counter must hold both the note table and the error half-period.
    localparam int unsigned TW = ($clog2(ERR_HALF + 1) > 17) ? $clog2(ERR_HALF + 1) : 17;

    typedef enum logic [1:0] {
        S_FOLLOW = 2'd0,
        S_ERR    = 2'd1,
        S_CHIME1 = 2'd2,
        S_CHIME2 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     dur_q, dur_d;
    logic [TW-1:0]   tone_q, tone_d;
    logic            sq_q, sq_d;
    logic            miss_d_q;
    logic [3:0]      prev_note_q;
    logic            piezo_q;
    logic [3:0]      active_q, active_d;
    logic            busy_q;
    logic            load;
    logic            miss_edge;
    logic [TW-1:0]   half_cur;

    function automatic logic [TW-1:0] note_half(input logic [3:0] code);
        logic [16:0] base;
        case (code)
            4'd1:    base = 17'd95556;
            4'd2:    base = 17'd85131;
            4'd3:    base = 17'd75843;
            4'd4:    base = 17'd71586;
            4'd5:    base = 17'd63776;
            4'd6:    base = 17'd56818;
            4'd7:    base = 17'd50619;
            4'd8:    base = 17'd47778;
            default: base = 17'd0;
        endcase
        return TW'(base >> DIV_SHIFT);
    endfunction

    assign miss_edge = miss & ~miss_d_q;

    // Effect sequencing; a miss edge overrides everything, including change_num.
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q + 32'd1;
        load    = 1'b0;
        if (miss_edge) begin
            state_d = S_ERR;
            dur_d   = '0;
            load    = 1'b1;
        end else begin
            case (state_q)
                S_FOLLOW: begin
                    dur_d = '0;
                    if (change_num) begin
                        state_d = S_CHIME1;
                        load    = 1'b1;
                    end else if (note != prev_note_q) begin
                        load = 1'b1;
                    end
                end
                S_ERR: begin
                    if (dur_q == 32'(ERR_LEN - 1)) begin
                        state_d = S_FOLLOW;
                        dur_d   = '0;
                        load    = 1'b1;
                    end
                end
                S_CHIME1, S_CHIME2: begin
                    if (change_num) begin
                        state_d = S_CHIME1;
                        dur_d   = '0;
                        load    = 1'b1;
                    end else if (dur_q == 32'(CHIME_LEN - 1)) begin
                        state_d = (state_q == S_CHIME1) ? S_CHIME2 : S_FOLLOW;
                        dur_d   = '0;
                        load    = 1'b1;
                    end
                end
                default: state_d = S_FOLLOW;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_FOLLOW: half_cur = note_half(prev_note_q);
            S_ERR:    half_cur = TW'(ERR_HALF);
            S_CHIME1: half_cur = note_half(4'd5);
            S_CHIME2: half_cur = note_half(4'd8);
            default:  half_cur = '0;
        endcase
    end

    always_comb begin
        tone_d = tone_q + TW'(1);
        sq_d   = sq_q;
        if (load || (half_cur == '0)) begin
            tone_d = '0;
            sq_d   = 1'b0;
        end else if (tone_q == half_cur - TW'(1)) begin
            tone_d = '0;
            sq_d   = ~sq_q;
        end
    end

    always_comb begin
        case (state_d)
            S_FOLLOW: active_d = ((note >= 4'd1) && (note <= 4'd8)) ? note : 4'd0;
            S_ERR:    active_d = 4'hF;
            S_CHIME1: active_d = 4'd5;
            S_CHIME2: active_d = 4'd8;
            default:  active_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FOLLOW;
            dur_q       <= '0;
            tone_q      <= '0;
            sq_q        <= 1'b0;
            miss_d_q    <= 1'b0;
            prev_note_q <= 4'd0;
            piezo_q     <= 1'b0;
            active_q    <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dur_q       <= dur_d;
            tone_q      <= tone_d;
            sq_q        <= sq_d;
            miss_d_q    <= miss;
            prev_note_q <= note;
            piezo_q     <= sq_d & enable;
            active_q    <= active_d;
            busy_q      <= (state_d != S_FOLLOW);
        end
    end

    assign piezo       = piezo_q;
    assign active_note = active_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Bench for piezo_tone_gen: a time-based reference model predicts
// {piezo, busy, active_note} each cycle; scenario tasks add fixed-value checks.
module tb_piezo_tone_gen;

    localparam int DIV_SHIFT = 8;
    localparam int ERR_HALF  = 10;
    localparam int ERR_LEN   = 100;
    localparam int CHIME_LEN = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] note;
    logic       miss;
    logic       change_num;
    logic       enable;
    logic       piezo;
    logic [3:0] active_note;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q[$];
    int note_table[9] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

    always #5 clk = ~clk;

    piezo_tone_gen #(
        .DIV_SHIFT(DIV_SHIFT),
        .ERR_HALF (ERR_HALF),
        .ERR_LEN  (ERR_LEN),
        .CHIME_LEN(CHIME_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .note       (note),
        .miss       (miss),
        .change_num (change_num),
        .enable     (enable),
        .piezo      (piezo),
        .active_note(active_note),
        .busy       (busy)
    );

    // Reference model: mode 0 follow, 1 error, 2 chime one, 3 chime two.
    // Tone output is derived from the time elapsed since the last phase origin.
    int         m_mode, m_eff_t, m_phase, m_code, m_half;
    logic [3:0] m_prev;
    logic       m_miss_d, m_medge, m_load, m_sq;

    always @(posedge clk) begin
        if (reset) begin
            m_mode   = 0;
            m_eff_t  = 0;
            m_phase  = 0;
            m_prev   = 4'd0;
            m_miss_d = 1'b0;
            exp_q.push_back(6'd0);
        end else begin
            m_medge  = miss && !m_miss_d;
            m_miss_d = miss;
            m_load   = 1'b0;
            m_eff_t  = m_eff_t + 1;
            m_phase  = m_phase + 1;
            if (m_medge) begin
                m_mode  = 1;
                m_eff_t = 0;
                m_load  = 1'b1;
            end else if (m_mode == 0) begin
                if (change_num) begin
                    m_mode  = 2;
                    m_eff_t = 0;
                    m_load  = 1'b1;
                end else if (note != m_prev) begin
                    m_load = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (m_eff_t == ERR_LEN) begin
                    m_mode = 0;
                    m_load = 1'b1;
                end
            end else begin
                if (change_num) begin
                    m_mode  = 2;
                    m_eff_t = 0;
                    m_load  = 1'b1;
                end else if (m_eff_t == CHIME_LEN) begin
                    m_mode  = (m_mode == 2) ? 3 : 0;
                    m_eff_t = 0;
                    m_load  = 1'b1;
                end
            end
            m_prev = note;
            if (m_load) m_phase = 0;
            case (m_mode)
                0:       m_code = (note >= 4'd1 && note <= 4'd8) ? int'(note) : 0;
                1:       m_code = 15;
                2:       m_code = 5;
                default: m_code = 8;
            endcase
            if (m_mode == 1)                   m_half = ERR_HALF;
            else if (m_code >= 1 && m_code <= 8) m_half = note_table[m_code] >> DIV_SHIFT;
            else                               m_half = 0;
            m_sq = (m_half != 0) && (((m_phase / m_half) % 2) == 1);
            exp_q.push_back({m_sq & enable, m_mode != 0, 4'(m_code)});
        end
    end

    // Advance to the next falling edge and fetch the DUT view and the model view.
    task automatic step(output logic [5:0] o, output logic [5:0] e);
        @(negedge clk);
        o = {piezo, busy, active_note};
        if (exp_q.size() != 0) e = exp_q[$];
        else e = 6'bx;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [5:0] o, e;
        reset = 1'b1;
        repeat (3) step(o, e);
        n_tests++;
        if (o !== 6'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", o, 6'd0); end
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_model: got %b want %b", o, e); end
        reset = 1'b0;
        step(o, e);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_release: got %b want %b", o, e); end
    endtask

    task automatic test_tone();
        logic [5:0] o, e;
        int   codes[2]  = '{1, 6};
        int   halves[2] = '{373, 221};
        int   k;
        logic prev;
        for (int t = 0; t < 2; t++) begin
            note = 4'(codes[t]);
            step(o, e);
            n_tests++;
            if (piezo !== 1'b0) begin n_fail++; $display("FAIL tone_load_low: got %b want 0", piezo); end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL tone_load_model: got %b want %b", o, e); end
            k = 0;
            do begin
                step(o, e);
                k++;
                n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL tone_model: got %b want %b", o, e); end
            end while (piezo !== 1'b1 && k < 2000);
            n_tests++;
            if (k != halves[t]) begin n_fail++; $display("FAIL tone_first_rise: got %0d want %0d", k, halves[t]); end
            k = 0;
            do begin
                prev = piezo;
                step(o, e);
                k++;
                n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL tone_model: got %b want %b", o, e); end
            end while (!(prev === 1'b0 && piezo === 1'b1) && k < 3000);
            n_tests++;
            if (k != 2 * halves[t]) begin n_fail++; $display("FAIL tone_period: got %0d want %0d", k, 2 * halves[t]); end
        end
    endtask

    task automatic test_silence();
        logic [5:0] o, e;
        for (int i = 0; i < 200; i++) begin
            note = (i < 100) ? 4'd0 : 4'd12;
            step(o, e);
            n_tests++;
            if (o !== 6'd0) begin n_fail++; $display("FAIL silence_outputs: got %b want %b", o, 6'd0); end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL silence_model: got %b want %b", o, e); end
        end
    endtask

    task automatic test_err();
        logic [5:0] o, e;
        int cnt;
        note = 4'd3;
        repeat (50) begin
            step(o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL err_pre_model: got %b want %b", o, e); end
        end
        miss = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 400; i++) begin
            step(o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL err_model: got %b want %b", o, e); end
            if (busy !== 1'b1) break;
            cnt++;
            n_tests++;
            if (active_note !== 4'hF) begin n_fail++; $display("FAIL err_active_note: got %h want f", active_note); end
        end
        n_tests++;
        if (cnt != ERR_LEN) begin n_fail++; $display("FAIL err_length: got %0d want %0d", cnt, ERR_LEN); end
        for (int i = 0; i < 300; i++) begin
            step(o, e);
            n_tests++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL err_no_retrigger: got %b want 0", busy); end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL err_post_model: got %b want %b", o, e); end
        end
        miss = 1'b0;
        step(o, e);
    endtask

    task automatic test_chime();
        logic [5:0] o, e;
        int n5, n8, nb;
        n5 = 0;
        n8 = 0;
        change_num = 1'b1;
        for (int i = 0; i < 130; i++) begin
            step(o, e);
            change_num = 1'b0;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL chime_model: got %b want %b", o, e); end
            if (busy === 1'b1 && active_note === 4'd5) n5++;
            if (busy === 1'b1 && active_note === 4'd8) n8++;
        end
        n_tests++;
        if (n5 != CHIME_LEN) begin n_fail++; $display("FAIL chime_tone1_len: got %0d want %0d", n5, CHIME_LEN); end
        n_tests++;
        if (n8 != CHIME_LEN) begin n_fail++; $display("FAIL chime_tone2_len: got %0d want %0d", n8, CHIME_LEN); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL chime_end_busy: got %b want 0", busy); end

        // Miss edge at chime cycle 20, then change_num inside the error buzz.
        change_num = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(o, e);
            change_num = 1'b0;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL chime_pre_miss_model: got %b want %b", o, e); end
        end
        miss = 1'b1;
        step(o, e);
        n_tests++;
        if ({busy, active_note} !== 5'h1F) begin n_fail++; $display("FAIL chime_miss_preempt: got %h want 1f", {busy, active_note}); end
        nb = 1;
        for (int i = 1; i < 150; i++) begin
            change_num = (i == 30);
            step(o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL chime_err_model: got %b want %b", o, e); end
            if (busy === 1'b1) nb++;
        end
        change_num = 1'b0;
        n_tests++;
        if (nb != ERR_LEN) begin n_fail++; $display("FAIL chime_ignored_in_err: got %0d want %0d", nb, ERR_LEN); end
        miss = 1'b0;
        step(o, e);
    endtask

    task automatic test_same_cycle();
        logic [5:0] o, e;
        int nb;
        miss       = 1'b1;
        change_num = 1'b1;
        step(o, e);
        change_num = 1'b0;
        n_tests++;
        if ({busy, active_note} !== 5'h1F) begin n_fail++; $display("FAIL same_cycle_err: got %h want 1f", {busy, active_note}); end
        nb = 1;
        for (int i = 1; i < 160; i++) begin
            step(o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL same_cycle_model: got %b want %b", o, e); end
            if (busy === 1'b1) nb++;
        end
        n_tests++;
        if (nb != ERR_LEN) begin n_fail++; $display("FAIL same_cycle_no_chime: got %0d want %0d", nb, ERR_LEN); end
        miss = 1'b0;
        step(o, e);
    endtask

    task automatic test_enable_err();
        logic [5:0] o, e;
        int nb;
        miss   = 1'b1;
        enable = 1'b0;
        nb     = 0;
        for (int i = 0; i < 150; i++) begin
            step(o, e);
            n_tests++;
            if (piezo !== 1'b0) begin n_fail++; $display("FAIL enable_piezo_low: got %b want 0", piezo); end
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL enable_model: got %b want %b", o, e); end
            if (busy === 1'b1) nb++;
        end
        n_tests++;
        if (nb != ERR_LEN) begin n_fail++; $display("FAIL enable_err_length: got %0d want %0d", nb, ERR_LEN); end
        enable = 1'b1;
        miss   = 1'b0;
        step(o, e);
    endtask

    task automatic test_reset_mid();
        logic [5:0] o, e;
        change_num = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step(o, e);
            change_num = 1'b0;
        end
        n_tests++;
        if ({busy, active_note} !== 5'h18) begin n_fail++; $display("FAIL reset_mid_in_chime2: got %h want 18", {busy, active_note}); end
        reset = 1'b1;
        step(o, e);
        reset = 1'b0;
        n_tests++;
        if (o !== 6'd0) begin n_fail++; $display("FAIL reset_mid_clear: got %b want %b", o, 6'd0); end
        step(o, e);
        miss  = 1'b1;
        reset = 1'b1;
        step(o, e);
        step(o, e);
        reset = 1'b0;
        step(o, e);
        n_tests++;
        if ({busy, active_note} !== 5'h1F) begin n_fail++; $display("FAIL reset_miss_held: got %h want 1f", {busy, active_note}); end
        for (int i = 0; i < 110; i++) begin
            step(o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL reset_post_model: got %b want %b", o, e); end
        end
        miss = 1'b0;
        step(o, e);
    endtask

    task automatic test_random();
        logic [5:0] o, e;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) note = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) miss = ~miss;
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            change_num = ($urandom_range(0, 149) == 0);
            reset      = ($urandom_range(0, 999) == 0);
            step(o, e);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL random_model: got %b want %b", o, e); end
        end
        reset      = 1'b0;
        change_num = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        note       = 4'd0;
        miss       = 1'b0;
        change_num = 1'b0;
        enable     = 1'b1;
        test_reset();
        test_tone();
        test_silence();
        test_err();
        test_chime();
        test_same_cycle();
        test_enable_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
